mc_controller: RTL
==================

# mc_controller

Moore-style control FSM that sequences the multi-cycle MIPS datapath. It decodes the opcode and funct fields of the instruction register and drives every datapath control strobe: PC update, IR/MDR load, register-file write, ALU operand muxes and ALU operation. It sits beside the datapath at the core top level and adds a memory wait-state handshake, an instruction-retire pulse and an illegal-instruction pulse.

## Interface
- No parameters. Opcode and funct encodings are fixed (see Operation).
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; forces state to S_RESET
- opcode  in  6  IR[31:26] from datapath
- funct  in  6  IR[5:0] from datapath
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA  out  1 each  datapath strobes
- ALUSrcB  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- instr_done  out  1  last cycle of a retiring instruction
- illegal  out  1  unsupported opcode/funct detected in DECODE
- state  out  4  current state (debug)

## Operation
- Encodings: S_RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, RTYPEEX 7, RTYPEWB 8, BEQEX 9, ADDIEX 10, ADDIWB 11, JEX 12. Codes 13-15: all outputs 0, next = FETCH.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010. Funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Every output not listed for a state is 0. Outputs depend only on state and mem_ready.
- S_RESET: all zero; next FETCH.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSource=00. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; else DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next: lw/sw→MEMADR, R with supported funct→RTYPEEX, beq→BEQEX, addi→ADDIEX, j→JEX; otherwise illegal=1 and next FETCH (no retire).
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next MEMRD if lw, MEMWR if sw.
- MEMRD: IorD=1, MemRead=1. Hold until mem_ready; then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1; next FETCH.
- MEMWR: IorD=1, MemWrite=1 (held through wait). instr_done=mem_ready; FETCH on mem_ready.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUControl from funct; next RTYPEWB.
- RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1; next FETCH. ALUControl is held at funct decode.
- BEQEX: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, instr_done=1; next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add; next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1; next FETCH.
- JEX: PCWrite=1, PCSource=10, instr_done=1; next FETCH.
- opcode/funct are sampled directly from IR. IR changes only on an IRWrite edge, so it is stable from DECODE onward.

## Timing
- Reset: state=S_RESET. All outputs 0, including state=0000. The first FETCH begins 1 cycle after reset deassertion.
- Reset mid-instruction: immediate abort to S_RESET. No strobe is asserted while reset is high.
- CPI with mem_ready tied to 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2. Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds 1 cycle.
- PCWrite/IRWrite pulse exactly 1 cycle per fetch, coincident with mem_ready=1.
- instr_done and illegal are 1-cycle pulses and never both high.

## Test plan
- Reset held 3 cycles, release, mem_ready=1 → state 0,0,0, then 1,2…; all strobes 0 while reset high; exactly one PCWrite+IRWrite in FETCH.
- lw (opcode 100011), mem_ready=1 → states 1,2,3,4,5,1. MEMWB shows RegWrite=1, MemtoReg=1, RegDst=0. instr_done high only in state 5.
- R-type funct 101010 → RTYPEEX ALUControl=100, RTYPEWB RegDst=1, RegWrite=1. Repeat for add/sub/and/or → 000/001/010/011.
- FETCH with mem_ready low for 3 cycles → state 1 held 4 cycles, IRWrite/PCWrite low for the first 3, high on the 4th only. sw with mem_ready low 2 cycles in MEMWR → MemWrite high 3 cycles, instr_done on the last.
- beq → BEQEX PCWriteCond=1, PCSource=01, ALUControl=001, PCWrite=0. j → JEX PCWrite=1, PCSource=10. Each takes 3 cycles total.
- Opcode 111111, or R-type funct 000111 → illegal pulses in DECODE, next state FETCH, instr_done never asserted. Assert reset during MEMRD → state 0 next sample, MemRead drops.

Source files
------------

// File: rtl/mc_controller_if.sv
// Handshake and strobe bundle between the multi-cycle MIPS control FSM and its datapath.
// master: controller side (samples IR fields and mem_ready, drives every strobe).
// slave: datapath/memory side (drives IR fields and mem_ready, consumes strobes).
interface mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUControl;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUControl,
           instr_done, illegal, state
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUControl,
           instr_done, illegal, state
  );
endinterface

// File: rtl/mc_controller.sv
// Moore control FSM sequencing the multi-cycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Ports: clk, reset (async, active-high), bus (mc_controller_if.master: IR fields, mem_ready, strobes, state).
// Strobes are registered from the next state; only mem_ready-qualified strobes and illegal are gated combinationally.
module mc_controller (
  input logic             clk,
  input logic             reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Per-state control word. in_fetch/in_memwr/in_decode are markers that let
  // the mem_ready- and opcode-dependent strobes be formed without a state compare.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_ctl;
    logic       done;
    logic       in_fetch;
    logic       in_decode;
    logic       in_memwr;
  } ctl_t;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    logic [2:0] a;
    case (f)
      6'b100010: a = ALU_SUB;
      6'b100100: a = ALU_AND;
      6'b100101: a = ALU_OR;
      6'b101010: a = ALU_SLT;
      default:   a = ALU_ADD;
    endcase
    return a;
  endfunction

  function automatic ctl_t ctl_of(input state_t s, input logic [2:0] rt_alu);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.in_fetch = 1'b1; end
      // Branch target is computed speculatively into ALUOut here.
      S_DECODE:  begin c.alu_src_b = 2'b11; c.in_decode = 1'b1; end
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.iord = 1'b1; c.mem_read = 1'b1; end
      S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; c.in_memwr = 1'b1; end
      S_RTYPEEX: begin c.alu_src_a = 1'b1; c.alu_ctl = rt_alu; end
      // ALU op held through writeback so the result stays stable while written.
      S_RTYPEWB: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; c.alu_ctl = rt_alu; end
      S_BEQEX:   begin
        c.alu_src_a = 1'b1; c.alu_ctl = ALU_SUB; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.done = 1'b1;
      end
      S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:  begin c.reg_write = 1'b1; c.done = 1'b1; end
      S_JEX:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.done = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  state_t     r_state;
  ctl_t       r_ctl;
  state_t     w_next;
  logic       w_is_r;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_legal;
  logic [2:0] w_rt_alu;

  assign w_is_r   = (bus.opcode == OP_R);
  assign w_is_lw  = (bus.opcode == OP_LW);
  assign w_is_sw  = (bus.opcode == OP_SW);
  assign w_rt_alu = funct_alu(bus.funct);
  assign w_legal  = w_is_lw || w_is_sw || (bus.opcode == OP_BEQ) ||
                    (bus.opcode == OP_ADDI) || (bus.opcode == OP_J) ||
                    (w_is_r && funct_ok(bus.funct));

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_RESET:   w_next = S_FETCH;
      S_FETCH:   w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_is_lw || w_is_sw)                       w_next = S_MEMADR;
        else if (w_is_r && funct_ok(bus.funct))       w_next = S_RTYPEEX;
        else if (bus.opcode == OP_BEQ)                w_next = S_BEQEX;
        else if (bus.opcode == OP_ADDI)               w_next = S_ADDIEX;
        else if (bus.opcode == OP_J)                  w_next = S_JEX;
        else                                          w_next = S_FETCH;
      end
      S_MEMADR:  w_next = w_is_lw ? S_MEMRD : (w_is_sw ? S_MEMWR : S_FETCH);
      S_MEMRD:   w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_RTYPEWB: w_next = S_FETCH;
      S_BEQEX:   w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JEX:     w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state it belongs to, so the
  // strobes come straight off flops. funct is stable when entering RTYPEEX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RESET;
      r_ctl   <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= ctl_of(w_next, w_rt_alu);
    end
  end

  // Fetch commits PC/IR, and a store retires, only in the cycle memory completes.
  assign bus.PCWrite     = r_ctl.pc_write | (r_ctl.in_fetch & bus.mem_ready);
  assign bus.IRWrite     = r_ctl.in_fetch & bus.mem_ready;
  assign bus.instr_done  = r_ctl.done | (r_ctl.in_memwr & bus.mem_ready);
  assign bus.illegal     = r_ctl.in_decode & ~w_legal;
  assign bus.PCWriteCond = r_ctl.pc_write_cond;
  assign bus.IorD        = r_ctl.iord;
  assign bus.MemRead     = r_ctl.mem_read;
  assign bus.MemWrite    = r_ctl.mem_write;
  assign bus.RegWrite    = r_ctl.reg_write;
  assign bus.RegDst      = r_ctl.reg_dst;
  assign bus.MemtoReg    = r_ctl.mem_to_reg;
  assign bus.ALUSrcA     = r_ctl.alu_src_a;
  assign bus.ALUSrcB     = r_ctl.alu_src_b;
  assign bus.PCSource    = r_ctl.pc_source;
  assign bus.ALUControl  = r_ctl.alu_ctl;
  assign bus.state       = r_state;

endmodule
